// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types and constants.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/register_file_32x32_read_port.sv
// One combinational read port: address decode, x0 forcing and write bypass.
module regfile_read_port #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            rst_n_i,
  input  logic            reg_write_i,
  input  logic [AW-1:0]   write_reg_i,
  input  logic [XLEN-1:0] write_data_i,
  input  logic [AW-1:0]   read_reg_i,
  input  logic [XLEN-1:0] regs_i [NREGS],
  output logic [XLEN-1:0] read_data_o
);
  import riscv_pkg::*;

  logic bypass_hit;

  assign bypass_hit = (BYPASS != 0) && reg_write_i
                      && (write_reg_i != AW'(REG_ZERO))
                      && (write_reg_i == read_reg_i);

  // Reset and x0 override everything, including the bypass path.
  always_comb begin
    read_data_o = '0;
    if (!rst_n_i || (read_reg_i == AW'(REG_ZERO))) begin
      read_data_o = '0;
    end else if (bypass_hit) begin
      read_data_o = write_data_i;
    end else begin
      read_data_o = regs_i[read_reg_i];
    end
  end
endmodule

// File: rtl/register_file_32x32.sv
// RISC-V integer register file: x0 hardwired to zero, synchronous writes,
// two combinational read ports with optional same-cycle write bypass.
module register_file_32x32 #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reg_write,
  input  logic [AW-1:0]   read_reg1,
  input  logic [AW-1:0]   read_reg2,
  input  logic [AW-1:0]   write_reg,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2
);
  import riscv_pkg::*;

  logic [XLEN-1:0] regs_q    [1:NREGS-1];
  logic [XLEN-1:0] regs_view [NREGS];
  logic            wr_en_d   [1:NREGS-1];

  assign regs_view[0] = '0;

  // x0 has no storage; every other register resets to zero.
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    assign wr_en_d[gi]   = reg_write && (write_reg == AW'(gi))
                           && (write_reg != AW'(REG_ZERO));
    assign regs_view[gi] = regs_q[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[gi] <= '0;
      end else if (wr_en_d[gi]) begin
        regs_q[gi] <= write_data;
      end
    end
  end

  regfile_read_port #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)
  ) u_rs1 (
    .rst_n_i      (rst_n),
    .reg_write_i  (reg_write),
    .write_reg_i  (write_reg),
    .write_data_i (write_data),
    .read_reg_i   (read_reg1),
    .regs_i       (regs_view),
    .read_data_o  (read_data1)
  );

  regfile_read_port #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)
  ) u_rs2 (
    .rst_n_i      (rst_n),
    .reg_write_i  (reg_write),
    .write_reg_i  (write_reg),
    .write_data_i (write_data),
    .read_reg_i   (read_reg2),
    .regs_i       (regs_view),
    .read_data_o  (read_data2)
  );
endmodule

// File: tb/tb_register_file_32x32.sv
// Scoreboard bench: one DUT with bypass, one without, driven in lockstep.
module tb_register_file_32x32;
  import riscv_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      reg_write = 1'b0;
  reg_addr_t read_reg1 = '0;
  reg_addr_t read_reg2 = '0;
  reg_addr_t write_reg = '0;
  word_t     write_data = '0;
  word_t     rd1_b, rd2_b, rd1_n, rd2_n;

  always #5 clk = ~clk;

  register_file_32x32 #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data),
    .read_data1(rd1_b), .read_data2(rd2_b)
  );

  register_file_32x32 #(.BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data),
    .read_data1(rd1_n), .read_data2(rd2_n)
  );

  typedef struct {
    int        id;
    reg_addr_t a1;
    reg_addr_t a2;
    word_t     e1_b;
    word_t     e2_b;
    word_t     e1_n;
    word_t     e2_n;
  } exp_t;

  exp_t  sb[$];
  word_t model [32];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_txn = 0;
  bit    stim_done = 1'b0;

  // Architectural view: what a read of addr returns during the current cycle.
  function automatic word_t ref_read(bit rst_ok, bit we, int wr, word_t wd,
                                     int addr, bit byp);
    if (!rst_ok || addr == 0) return '0;
    if (byp && we && wr != 0 && wr == addr) return wd;
    return model[addr];
  endfunction

  task automatic issue(bit rst_ok, bit we, int wr, word_t wd, int r1, int r2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = rst_ok;
    reg_write  = we;
    write_reg  = reg_addr_t'(wr);
    write_data = wd;
    read_reg1  = reg_addr_t'(r1);
    read_reg2  = reg_addr_t'(r2);
    e.id   = n_txn;
    e.a1   = reg_addr_t'(r1);
    e.a2   = reg_addr_t'(r2);
    if (!rst_ok) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end
    e.e1_b = ref_read(rst_ok, we, wr, wd, r1, 1'b1);
    e.e2_b = ref_read(rst_ok, we, wr, wd, r2, 1'b1);
    e.e1_n = ref_read(rst_ok, we, wr, wd, r1, 1'b0);
    e.e2_n = ref_read(rst_ok, we, wr, wd, r2, 1'b0);
    sb.push_back(e);
    n_txn++;
    // The write lands on the coming edge, before the next transaction reads.
    if (rst_ok && we && wr != 0) model[wr] = wd;
  endtask

  task automatic chk(string name, int id, word_t act, word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s txn %0d: got %08h expected %08h", name, id, act, exp);
    end
  endtask

  // Monitor: outputs are stable by the falling edge of each issued cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd1_bypass",   e.id, rd1_b, e.e1_b);
        chk("rd2_bypass",   e.id, rd2_b, e.e2_b);
        chk("rd1_nobypass", e.id, rd1_n, e.e1_n);
        chk("rd2_nobypass", e.id, rd2_n, e.e2_n);
        $display("txn %0d r1=%0d r2=%0d d1=%08h/%08h d2=%08h/%08h",
                 e.id, e.a1, e.a2, rd1_b, rd1_n, rd2_b, rd2_n);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr, r1, r2;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset and asynchronous clear of a loaded register, write lost in reset.
    issue(0, 1, 5, 32'h1111_1111, 5, 0);
    issue(1, 1, 5, 32'hDEAD_BEEF, 5, 0);
    issue(1, 0, 0, '0, 5, 5);
    issue(0, 1, 5, 32'h0000_1234, 5, 5);
    issue(1, 0, 0, '0, 5, 5);

    // Basic write then dual read of the same address.
    issue(1, 1, 10, 32'h0000_1234, 0, 0);
    issue(1, 0, 0, '0, 10, 10);

    // x0 protection, including a bypass compare on address 0.
    issue(1, 1, 0, 32'hFFFF_FFFF, 0, 0);
    issue(1, 0, 0, '0, 0, 0);

    // Bypass vs. no bypass, second port unaffected.
    issue(1, 1, 7, 32'h0000_0001, 0, 0);
    issue(1, 1, 8, 32'h0BAD_F00D, 0, 0);
    issue(1, 1, 7, 32'hA5A5_A5A5, 7, 8);
    issue(1, 0, 0, '0, 7, 8);
    issue(1, 1, 9, 32'h9999_0000, 9, 9);

    // Write enable low: no update, no bypass.
    issue(1, 1, 3, 32'h0000_0099, 0, 0);
    issue(1, 0, 3, 32'h0000_0055, 3, 3);
    issue(1, 0, 0, '0, 3, 3);

    // Sweep every register, then read mirrored pairs.
    for (int i = 1; i < 32; i++) issue(1, 1, i, i * 32'h0101_0101, 0, 0);
    for (int i = 0; i < 32; i++) issue(1, 0, 0, '0, i, 31 - i);

    // Randomized traffic with frequent address collisions and rare resets.
    for (int n = 0; n < 300; n++) begin
      wr = int'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wr : int'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wr : int'($urandom_range(0, 31));
      issue(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1,
            wr, word_t'($urandom()), r1, r2);
    end

    issue(1, 0, 0, '0, 0, 0);
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    stim_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- Integer register file for the single-cycle RISC-V datapath.
- Directly downstream of the write-back select mux: it consumes the selected result (ALU result or memory read data) as write data.
- Its two read ports feed the ALU operand path and the ALU-source select mux.
- Holds x0..x31. x0 is hardwired to zero. Writes are synchronous; reads are combinational, with optional same-cycle write-to-read bypass.

Parameters:
- XLEN, 32, data width of each register and of the data ports.
- NREGS, 32, number of architectural registers (must equal 2**AW).
- AW, 5, register address width.
- BYPASS, 1, 1 = a read of the register being written this cycle returns write_data; 0 = it returns the old contents.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- reg_write  input  1  write enable, from the control unit RegWrite.
- read_reg1  input  AW  rs1 address, instruction[19:15].
- read_reg2  input  AW  rs2 address, instruction[24:20].
- write_reg  input  AW  rd address, instruction[11:7].
- write_data  input  XLEN  write-back value from the write-back select mux.
- read_data1  output  XLEN  rs1 contents, to the ALU input A.
- read_data2  output  XLEN  rs2 contents, to the ALU-source mux and data memory write data.

Behaviour:
- Reset:
  - Asynchronous and active-low: clk and rst_n are the single clock and asynchronous active-low reset.
  - rst_n low clears every register x1..x31 to 0 immediately, without waiting for clk.
  - While rst_n is low, read_data1 and read_data2 are 0 for every address, and bypass is suppressed.
  - Writes are ignored while rst_n is low.
  - rst_n deasserts asynchronously. The first write can occur on the first rising clk edge with rst_n high.
- Write:
  - On a rising clk edge with rst_n=1, reg_write=1 and write_reg!=0, regs[write_reg] <= write_data.
  - Latency is one edge: the new value is visible on the read ports after the edge.
- x0:
  - write_reg=0 with reg_write=1 has no effect.
  - A read of address 0 always returns 0, including under bypass.
- Read:
  - Purely combinational: read_dataN = regs[read_regN], with zero latency.
  - Reads are sensitive to address, register contents, and the bypass inputs.
- Bypass (BYPASS=1):
  - If reg_write=1, write_reg!=0 and write_reg==read_regN, then read_dataN = write_data in the same cycle, before the edge.
  - Each port is evaluated independently. Both ports may bypass simultaneously when both addresses equal write_reg.
- BYPASS=0: a read in the same cycle as a write to the same address returns the pre-edge value.
- Dual read of the same address: both ports return identical data.
- Reset mid-operation: a write pending in a cycle where rst_n falls before the edge is lost; the register reads 0.
- No X propagation from unwritten registers: every storage element has a reset value.
- No other state, no stalls, no handshake. The block always accepts one write and services two reads per cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and REG_ADDR_W constants.
  - REG_ZERO = 5'd0 localparam.
  - A reg_addr_t typedef.
  - A word_t typedef.
- One natural sub-module: regfile_read_port. It performs the address decode, the x0 forcing and the bypass compare, and is instantiated twice (rs1 and rs2). Storage and write logic stay in the top module.

Test Plan:
- Reset:
  - Stimulus: pulse rst_n low mid-cycle after loading x5=32'hDEADBEEF.
  - Required: read_data1 with read_reg1=5 reads 0 immediately, without waiting for a clk edge, and stays 0 after release.
- Basic write/read:
  - Stimulus: write x10=32'h0000_1234 (reg_write=1, write_reg=10), then read_reg1=10 and read_reg2=10 next cycle.
  - Required: both ports read 32'h0000_1234.
- x0 protection:
  - Stimulus: reg_write=1, write_reg=0, write_data=32'hFFFF_FFFF; then read_reg1=0.
  - Required: read_data1=0 both before and after the edge; a bypass compare on address 0 also gives 0.
- Bypass:
  - Stimulus: BYPASS=1, x7 holds 32'h1. Same cycle: reg_write=1, write_reg=7, write_data=32'hA5A5_A5A5, read_reg1=7, read_reg2=8.
  - Required: read_data1=32'hA5A5_A5A5 before the edge; read_data2 unchanged.
  - Stimulus: repeat with BYPASS=0.
  - Required: read_data1=32'h1 before the edge and 32'hA5A5_A5A5 after it.
- Write enable low:
  - Stimulus: reg_write=0, write_reg=3, write_data=32'h55.
  - Required: x3 is unchanged after the edge, and no bypass occurs.
- Sweep:
  - Stimulus: write x1..x31 with value = index*32'h0101_0101 on consecutive cycles, then read all pairs (i, 31-i).
  - Required: every read matches the written value, and x0 reads 0.
